// File: rtl/mem_access_ctrl.sv
// Data-memory access controller behind the MEM stage. It turns a single-cycle
// load/store request into a req/ack bus transaction and stalls the pipeline until the access completes.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic req;
    logic aligned;

    assign req     = mem_ren | mem_wen;
    assign aligned = (mem_addr[1:0] == 2'b00);

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so
        // no branch below can leave one unassigned and infer a latch.
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (aligned) begin
                        state_d     = BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wen;
                        bus_addr_d  = mem_addr;
                        bus_wdata_d = mem_dout;
                        cnt_d       = 8'd0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                    end
                end
            end
            BUSY: begin
                // An ack arriving in the last allowed cycle still completes the access.
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        rdata_d = bus_rdata;
                    end
                    err_d     = 1'b0;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = ERR_RDATA;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the values computed for this cycle regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Stall is gated by rst_n so the hold drops at once even if the MEM stage keeps requesting.
    assign mem_stall = rst_n & (((state_q == IDLE) & req) | (state_q == BUSY));
    assign mem_din   = rdata_q;
    assign mem_err   = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule
